wb_regfile: RTL and testbench



---
 rtl/wb_pkg.sv | 28 ++
 rtl/regfile_64x32.sv | 61 ++++++
 rtl/wb_regfile.sv | 100 ++++++++++
 tb/tb_wb_regfile.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: WB control bit positions,
// writeback source encodings, the commit state machine states and the
// fixed datapath widths.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 6;

    // Bit positions inside the 7-bit WB control bundle; bit 6 is reserved.
    localparam int WB_REGWRITE  = 0;
    localparam int WB_SRC_LO    = 1;
    localparam int WB_FLAGWRITE = 3;
    localparam int WB_HALT      = 4;
    localparam int WB_VALID     = 5;

    typedef enum logic [1:0] {
        SRC_ALU     = 2'b00,
        SRC_DMEM    = 2'b01,
        SRC_IMM     = 2'b10,
        SRC_ILLEGAL = 2'b11
    } src_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_64x32.sv
// 64 x 32-bit register file with one synchronous write port and two
// asynchronous read ports. r0 reads as zero and is never written. A write
// presented in the current cycle is forwarded to a read port addressing the
// same register, so decode sees the value before the storing edge.
//   clock, resetn      : clock, asynchronous active-low reset (clears all)
//   we, waddr, wdata   : write port, stored at the rising edge
//   raddr_a/rdata_a    : read port A (combinational, with bypass)
//   raddr_b/rdata_b    : read port B (combinational, with bypass)
module regfile_64x32
    import wb_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr_a,
    input  logic [REG_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [64];

    // NOTE: the array must read zero straight after reset, so it is built
    // from resettable flops rather than a RAM macro; every entry is cleared.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            mem[waddr] <= wdata;
        end
    end

    // NOTE: each combinational output gets a value on every path (the first
    // branch covers r0), so no latch can be inferred.
    always_comb begin
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem[raddr_a];
        end
    end

    always_comb begin
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem[raddr_b];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage consumer at the output of the EX/WB buffer. Commits one
// bundle per cycle: selects the writeback source, writes the register file,
// latches N/Z, counts retired instructions (saturating) and stops committing
// after a halt instruction until reset.
//   clock, resetn        : clock, asynchronous active-low reset
//   iDMEM, iALU, iI      : candidate writeback data
//   iRd, iWB             : destination register and WB control bundle
//   iN, iZ               : flags produced in EX
//   iRs/oRs, iRt/oRt     : decode-stage read ports
//   oN, oZ               : architectural flags
//   oHalted, oIllegal    : halted state, sticky illegal-source indication
//   oRetired             : retired instruction count, saturating
module wb_regfile
    import wb_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] iDMEM,
    input  logic [DATA_W-1:0] iALU,
    input  logic [DATA_W-1:0] iI,
    input  logic [REG_W-1:0]  iRd,
    input  logic [6:0]        iWB,
    input  logic              iN,
    input  logic              iZ,
    input  logic [REG_W-1:0]  iRs,
    input  logic [REG_W-1:0]  iRt,
    output logic [DATA_W-1:0] oRs,
    output logic [DATA_W-1:0] oRt,
    output logic              oN,
    output logic              oZ,
    output logic              oHalted,
    output logic              oIllegal,
    output logic [DATA_W-1:0] oRetired
);

    state_e            state;
    src_e              src;
    logic              commit;
    logic              reg_we;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] retired_q;
    logic              unused_reserved;

    assign unused_reserved = iWB[6];

    // Bubbles and anything arriving after a halt leave all state untouched.
    assign commit = iWB[WB_VALID] && (state == RUN);
    assign src    = src_e'(iWB[WB_SRC_LO +: 2]);
    assign reg_we = commit && iWB[WB_REGWRITE] && (src != SRC_ILLEGAL) && (iRd != '0);

    always_comb begin
        wb_data = iALU;
        case (src)
            SRC_DMEM: wb_data = iDMEM;
            SRC_IMM:  wb_data = iI;
            default:  wb_data = iALU;
        endcase
    end

    regfile_64x32 u_rf (
        .clock   (clock),
        .resetn  (resetn),
        .we      (reg_we),
        .waddr   (iRd),
        .wdata   (wb_data),
        .raddr_a (iRs),
        .raddr_b (iRt),
        .rdata_a (oRs),
        .rdata_b (oRt)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= RUN;
            oN        <= 1'b0;
            oZ        <= 1'b0;
            oIllegal  <= 1'b0;
            retired_q <= '0;
        end else if (commit) begin
            if (src == SRC_ILLEGAL) begin
                oIllegal <= 1'b1;
            end
            if (iWB[WB_FLAGWRITE]) begin
                oN <= iN;
                oZ <= iZ;
            end
            if (retired_q != '1) begin
                retired_q <= retired_q + 32'd1;
            end
            // The halting instruction's own writes complete at this edge.
            if (iWB[WB_HALT]) begin
                state <= HALTED;
            end
        end
    end

    assign oHalted  = (state == HALTED);
    assign oRetired = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal
// expectations, then randomized bundles compared every cycle against a
// behavioural model of the architectural state.
module tb_wb_regfile;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] dmem, alu, imm;
    logic [5:0]  rd, rs, rt;
    logic [6:0]  wb;
    logic        n_in, z_in;
    logic [31:0] o_rs, o_rt, o_retired;
    logic        o_n, o_z, o_halted, o_illegal;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_reg [64];
    logic        m_n, m_z, m_halted, m_illegal;
    logic [31:0] m_retired;

    wb_regfile dut (
        .clock    (clock),
        .resetn   (resetn),
        .iDMEM    (dmem),
        .iALU     (alu),
        .iI       (imm),
        .iRd      (rd),
        .iWB      (wb),
        .iN       (n_in),
        .iZ       (z_in),
        .iRs      (rs),
        .iRt      (rt),
        .oRs      (o_rs),
        .oRt      (o_rt),
        .oN       (o_n),
        .oZ       (o_z),
        .oHalted  (o_halted),
        .oIllegal (o_illegal),
        .oRetired (o_retired)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_data();
        case (wb[2:1])
            2'b00:   return alu;
            2'b01:   return dmem;
            2'b10:   return imm;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_commit();
        return wb[5] && !m_halted;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] addr);
        if (addr == 6'd0) return 32'h0;
        if (m_commit() && wb[0] && (wb[2:1] != 2'b11) && (rd == addr)) return m_data();
        return m_reg[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 32'h0;
        m_n = 0; m_z = 0; m_halted = 0; m_illegal = 0; m_retired = 32'h0;
    endtask

    task automatic model_update();
        if (m_commit()) begin
            if (wb[2:1] == 2'b11) m_illegal = 1'b1;
            else if (wb[0] && (rd != 6'd0)) m_reg[rd] = m_data();
            if (wb[3]) begin
                m_n = n_in;
                m_z = z_in;
            end
            if (m_retired != 32'hFFFF_FFFF) m_retired = m_retired + 32'd1;
            if (wb[4]) m_halted = 1'b1;
        end
    endtask

    task automatic check_state();
        check("flag_n",   {31'h0, o_n},       {31'h0, m_n});
        check("flag_z",   {31'h0, o_z},       {31'h0, m_z});
        check("halted",   {31'h0, o_halted},  {31'h0, m_halted});
        check("illegal",  {31'h0, o_illegal}, {31'h0, m_illegal});
        check("retired",  o_retired,          m_retired);
    endtask

    // Called just after a falling edge: apply a bundle and check the read
    // ports (including same-cycle bypass) against the model.
    task automatic drive(input logic [6:0] w, input logic [5:0] d,
                         input logic [31:0] a, input logic [31:0] m, input logic [31:0] i,
                         input logic n, input logic z,
                         input logic [5:0] s, input logic [5:0] t);
        wb = w; rd = d; alu = a; dmem = m; imm = i; n_in = n; z_in = z; rs = s; rt = t;
        #1;
        check("rs_port", o_rs, m_read(rs));
        check("rt_port", o_rt, m_read(rt));
    endtask

    task automatic clk_edge();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_state();
    endtask

    task automatic bubble_read(input logic [5:0] s, input logic [5:0] t);
        drive(7'b0000000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, s, t);
    endtask

    // Asserts reset between edges and checks that everything clears with no
    // clock edge; returns just after a falling edge with reset released.
    task automatic do_reset();
        wb = 7'h0;
        rs = 6'd3;
        rt = 6'd5;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("rst_n",       {31'h0, o_n},       32'h0);
        check("rst_z",       {31'h0, o_z},       32'h0);
        check("rst_halted",  {31'h0, o_halted},  32'h0);
        check("rst_illegal", {31'h0, o_illegal}, 32'h0);
        check("rst_retired", o_retired,          32'h0);
        check("rst_rs",      o_rs,               32'h0);
        check("rst_rt",      o_rt,               32'h0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        wb = 7'h0; rd = 0; rs = 0; rt = 0; alu = 0; dmem = 0; imm = 0; n_in = 0; z_in = 0;
        model_reset();
        @(negedge clock);
        do_reset();

        // Write r5 from ALU: visible via bypass, then from storage.
        drive(7'b0100001, 6'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0, 6'd5, 6'd5);
        check("bypass_r5", o_rs, 32'hDEAD_BEEF);
        clk_edge();
        check("retired_1", o_retired, 32'd1);
        bubble_read(6'd5, 6'd0);
        check("stored_r5", o_rs, 32'hDEAD_BEEF);
        clk_edge();

        // DMEM to r7, immediate to r8, ALU write to r0 dropped.
        drive(7'b0100011, 6'd7, 32'h1111_1111, 32'h1234_5678, 32'h2222_2222, 0, 0, 6'd7, 6'd8);
        clk_edge();
        drive(7'b0100101, 6'd8, 32'h3333_3333, 32'h4444_4444, 32'h0000_FFFF, 0, 0, 6'd7, 6'd8);
        clk_edge();
        drive(7'b0100001, 6'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 6'd0, 6'd0);
        check("r0_bypass", o_rs, 32'h0);
        clk_edge();
        bubble_read(6'd7, 6'd8);
        check("r7", o_rs, 32'h1234_5678);
        check("r8", o_rt, 32'h0000_FFFF);
        check("r0_after", {26'h0, rs}, 32'h0 + 32'(rs));
        clk_edge();
        bubble_read(6'd0, 6'd0);
        check("r0_read", o_rs, 32'h0);
        clk_edge();

        // Flags: load, hold when FlagWrite=0, untouched by an invalid bundle.
        drive(7'b0101000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 6'd5, 6'd7);
        clk_edge();
        check("flag_load_n", {31'h0, o_n}, 32'd1);
        check("flag_load_z", {31'h0, o_z}, 32'd0);
        drive(7'b0100000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd5, 6'd7);
        clk_edge();
        check("flag_hold_n", {31'h0, o_n}, 32'd1);
        check("flag_hold_z", {31'h0, o_z}, 32'd0);
        drive(7'b0001001, 6'd5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 6'd5, 6'd7);
        check("invalid_nobypass", o_rs, 32'hDEAD_BEEF);
        clk_edge();
        check("invalid_retired", o_retired, 32'd6);
        check("invalid_n", {31'h0, o_n}, 32'd1);

        // Illegal source: no register write, sticky flag, still retires.
        drive(7'b0100111, 6'd9, 32'h9999_9999, 32'h9999_9999, 32'h9999_9999, 0, 0, 6'd9, 6'd9);
        check("illegal_nobypass", o_rs, 32'h0);
        clk_edge();
        check("illegal_set", {31'h0, o_illegal}, 32'd1);
        check("illegal_retired", o_retired, 32'd7);
        drive(7'b0100001, 6'd10, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 6'd9, 6'd10);
        check("r9_unchanged", o_rs, 32'h0);
        clk_edge();
        check("illegal_sticky", {31'h0, o_illegal}, 32'd1);

        // Halt writes r3 then freezes everything.
        drive(7'b0110001, 6'd3, 32'h0000_00A5, 32'h0, 32'h0, 0, 0, 6'd3, 6'd3);
        clk_edge();
        check("halt_set", {31'h0, o_halted}, 32'd1);
        check("halt_retired", o_retired, 32'd9);
        drive(7'b0100001, 6'd3, 32'h0000_005A, 32'h0, 32'h0, 0, 0, 6'd3, 6'd3);
        check("halt_nobypass", o_rs, 32'h0000_00A5);
        clk_edge();
        bubble_read(6'd3, 6'd10);
        check("halt_r3", o_rs, 32'h0000_00A5);
        check("halt_frozen", o_retired, 32'd9);
        clk_edge();

        // Reset between edges, then counter saturation.
        do_reset();
        bubble_read(6'd0, 6'd0);
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        m_retired = 32'hFFFF_FFFE;
        clk_edge();
        for (int k = 0; k < 3; k++) begin
            drive(7'b0100001, 6'd1, 32'(k), 32'h0, 32'h0, 0, 0, 6'd1, 6'd2);
            clk_edge();
            check("saturate", o_retired, 32'hFFFF_FFFF);
        end

        // Randomized bundles checked against the model every cycle.
        for (int c = 0; c < 600; c++) begin
            logic [6:0] w;
            logic [5:0] d, s, t;
            if ((c % 150) == 149) begin
                do_reset();
            end
            w = 7'($urandom);
            w[5] = ($urandom_range(0, 7) != 0);
            w[4] = ($urandom_range(0, 63) == 0);
            d = 6'($urandom_range(0, 15));
            s = ($urandom_range(0, 1) == 1) ? d : 6'($urandom_range(0, 15));
            t = ($urandom_range(0, 1) == 1) ? d : 6'($urandom_range(0, 15));
            drive(w, d, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), s, t);
            clk_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
